// File: rtl/fft_butterfly_sequencer_if.sv
// ---------------------------------------------------------------------------
// fft_butterfly_sequencer_if
// Purpose : bundles the control and handshake signals of the FFT butterfly
//           sequencer so the top level, RAM controller and compute unit can
//           attach through a single port.
// Signals :
//   start, abort          top-level run request / cancel (into sequencer)
//   busy, done, error     run status (out of sequencer)
//   stage                 current stage index
//   rd_en, wr_en          RAM read / write requests, held until mem_ready
//   mem_ready             RAM controller completion
//   a_addr, b_addr        butterfly upper / lower leg addresses
//   tw_addr               twiddle address, MSB selects the twiddle region
//   cu_start, cu_done     compute unit start pulse / result valid
// Modports: master = the sequencer, slave = its environment.
// ---------------------------------------------------------------------------
interface fft_butterfly_sequencer_if #(
  parameter int LOG2N = 10
) ();
  logic             start;
  logic             abort;
  logic             busy;
  logic             done;
  logic             error;
  logic [3:0]       stage;
  logic             rd_en;
  logic             wr_en;
  logic             mem_ready;
  logic [LOG2N-1:0] a_addr;
  logic [LOG2N-1:0] b_addr;
  logic [LOG2N:0]   tw_addr;
  logic             cu_start;
  logic             cu_done;

  modport master (
    input  start, abort, mem_ready, cu_done,
    output busy, done, error, stage, rd_en, wr_en, a_addr, b_addr, tw_addr, cu_start
  );

  modport slave (
    output start, abort, mem_ready, cu_done,
    input  busy, done, error, stage, rd_en, wr_en, a_addr, b_addr, tw_addr, cu_start
  );
endinterface

// File: rtl/fft_butterfly_sequencer.sv
// ---------------------------------------------------------------------------
// fft_butterfly_sequencer
// Purpose : walks every butterfly of every stage of a radix-2 in-place FFT
//           over a shared sample/twiddle RAM. For each butterfly it reads the
//           operands, hands them to the compute unit, writes the result back
//           and then steps the offset / group / stage counters.
// Ports   :
//   MAX10_CLK1_50  clock, all logic on the rising edge
//   reset          synchronous active-high reset
//   bus            fft_butterfly_sequencer_if.master (start/abort, status,
//                  RAM request/ready, addresses, compute start/done)
// Parameters:
//   LOG2N       log2 of the FFT length
//   CU_TIMEOUT  max cycles spent waiting for cu_done (0 disables the limit)
// ---------------------------------------------------------------------------
module fft_butterfly_sequencer #(
  parameter int LOG2N      = 10,
  parameter int CU_TIMEOUT = 255
) (
  input logic                          MAX10_CLK1_50,
  input logic                          reset,
  fft_butterfly_sequencer_if.master    bus
);

  localparam int CNTW = (CU_TIMEOUT > 1) ? $clog2(CU_TIMEOUT + 1) : 1;
  localparam logic [CNTW-1:0] CU_LAST    = CNTW'(CU_TIMEOUT - 1);
  localparam logic [3:0]      LAST_STAGE = 4'(LOG2N - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] READ    = 3'd1;
  localparam logic [2:0] COMPUTE = 3'd2;
  localparam logic [2:0] WRITE   = 3'd3;
  localparam logic [2:0] ADVANCE = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [3:0]       stage_q, stage_d;
  logic [LOG2N-1:0] group_q, group_d;
  logic [LOG2N-1:0] offset_q, offset_d;
  logic [LOG2N-1:0] aAddr_q, aAddr_d;
  logic [LOG2N-1:0] bAddr_q, bAddr_d;
  logic [LOG2N:0]   twAddr_q, twAddr_d;
  logic [CNTW-1:0]  cuCnt_q, cuCnt_d;
  logic             cuStart_q, cuStart_d;
  logic             error_q, error_d;

  logic [LOG2N-1:0] span;
  logic [LOG2N-1:0] offsetInc;
  logic [LOG2N-1:0] groupInc;
  logic             lastOffset;
  logic             lastGroup;
  logic             lastButterfly;
  logic             loadAddr;

  // Butterfly span is 2^s; a group spans twice that. In the final stage the
  // group step equals N and wraps to zero, which doubles as the end-of-stage
  // test for every stage.
  always_comb begin
    span          = LOG2N'(1) << stage_q;
    offsetInc     = offset_q + LOG2N'(1);
    groupInc      = group_q + (span << 1);
    lastOffset    = (offsetInc == span);
    lastGroup     = (groupInc == '0);
    lastButterfly = lastOffset && lastGroup && (stage_q == LAST_STAGE);
  end

  // Next-state logic. Abort outranks everything outside IDLE; in IDLE it
  // simply blocks a simultaneous start. Addresses are only reloaded when a new
  // butterfly begins, so they stay stable from READ through WRITE.
  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    group_d   = group_q;
    offset_d  = offset_q;
    cuCnt_d   = cuCnt_q;
    error_d   = error_q;
    cuStart_d = 1'b0;
    loadAddr  = 1'b0;

    if (bus.abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            state_d  = READ;
            stage_d  = '0;
            group_d  = '0;
            offset_d = '0;
            error_d  = 1'b0;
            loadAddr = 1'b1;
          end
        end
        READ: begin
          if (bus.mem_ready) begin
            state_d   = COMPUTE;
            cuCnt_d   = '0;
            cuStart_d = 1'b1;
          end
        end
        COMPUTE: begin
          if (bus.cu_done) begin
            state_d = WRITE;
          end else if (CU_TIMEOUT != 0) begin
            if (cuCnt_q == CU_LAST) begin
              state_d = IDLE;
              error_d = 1'b1;
            end else begin
              cuCnt_d = cuCnt_q + CNTW'(1);
            end
          end
        end
        WRITE: begin
          if (bus.mem_ready) begin
            state_d = ADVANCE;
          end
        end
        ADVANCE: begin
          if (lastButterfly) begin
            state_d = DONE;
          end else begin
            state_d  = READ;
            loadAddr = 1'b1;
            if (!lastOffset) begin
              offset_d = offsetInc;
            end else begin
              offset_d = '0;
              if (!lastGroup) begin
                group_d = groupInc;
              end else begin
                group_d = '0;
                stage_d = stage_q + 4'd1;
              end
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Butterfly addresses for the counters about to take effect.
  always_comb begin
    aAddr_d  = aAddr_q;
    bAddr_d  = bAddr_q;
    twAddr_d = twAddr_q;
    if (loadAddr) begin
      aAddr_d  = group_d + offset_d;
      bAddr_d  = (group_d + offset_d) + (LOG2N'(1) << stage_d);
      twAddr_d = {1'b1, offset_d << (LAST_STAGE - stage_d)};
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      state_q   <= IDLE;
      stage_q   <= '0;
      group_q   <= '0;
      offset_q  <= '0;
      aAddr_q   <= '0;
      bAddr_q   <= '0;
      twAddr_q  <= {1'b1, {LOG2N{1'b0}}};
      cuCnt_q   <= '0;
      cuStart_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      group_q   <= group_d;
      offset_q  <= offset_d;
      aAddr_q   <= aAddr_d;
      bAddr_q   <= bAddr_d;
      twAddr_q  <= twAddr_d;
      cuCnt_q   <= cuCnt_d;
      cuStart_q <= cuStart_d;
      error_q   <= error_d;
    end
  end

  // Outputs decode straight from state so rd_en, wr_en and cu_start can
  // never overlap.
  always_comb begin
    bus.busy     = (state_q != IDLE);
    bus.done     = (state_q == DONE);
    bus.rd_en    = (state_q == READ);
    bus.wr_en    = (state_q == WRITE);
    bus.cu_start = cuStart_q;
    bus.error    = error_q;
    bus.stage    = stage_q;
    bus.a_addr   = aAddr_q;
    bus.b_addr   = bAddr_q;
    bus.tw_addr  = twAddr_q;
  end

endmodule
